mm_bram_parallel_ctrl: RTL
==========================

Name: mm_bram_parallel_ctrl

Overview:
Sequencer for the parallel BRAM matrix-multiply datapath. On start, it streams row addresses to the source SRAM and aligns dpath_sum_en/dpath_result_wraddr with the returned row data. It then counts datapath write-backs until every issued row has retired, and reports done plus a lane-consistency error flag. It sits between the top-level command interface and the datapath/source-SRAM pair.

Parameters:
ROW_NUM, 32, max rows per job; also the source/result SRAM depth
COL_NUM, 32, datapath column lanes (width of row_wr_en)
RD_LAT, 1, source SRAM read latency in cycles, range 1..4
ROW_ADDR_WIDTH, $clog2(ROW_NUM), derived, not set manually
CNT_WIDTH, $clog2(ROW_NUM+1), derived; width of row counts

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-high reset
start  in  1  one-cycle job request; accepted only in IDLE
num_rows  in  CNT_WIDTH  rows in job, sampled when start is accepted; 0..ROW_NUM
hold  in  1  pauses issue of new rows; in-flight rows continue
busy  out  1  high from the cycle after start is accepted until done
done  out  1  one-cycle pulse when the job completes
err  out  1  sticky lane-mismatch flag; cleared on next accepted start
src_rd_en  out  1  source SRAM read strobe
src_rd_addr  out  ROW_ADDR_WIDTH  source SRAM row address
dpath_sum_en  out  1  to datapath val_in; row data valid this cycle
dpath_result_wraddr  out  ROW_ADDR_WIDTH  to datapath addr_i_in
row_wr_en  in  COL_NUM  per-lane write strobes returned by datapath

Behaviour:
- Reset: state=IDLE; all outputs 0; counters 0; delay line valid bits cleared. Reset mid-job abandons the job silently, with no done pulse.
- FSM IDLE -> ISSUE on start with num_rows>0; IDLE -> DONE on start with num_rows=0; ISSUE -> DRAIN after the last row is issued; DRAIN -> DONE when retired==num_rows_latched; DONE -> IDLE unconditionally after 1 cycle.
- done=1 only in the DONE cycle. busy=1 in ISSUE and DRAIN.
- ISSUE: each cycle with hold=0, drive src_rd_en=1 and src_rd_addr=issue_cnt, then increment issue_cnt. With hold=1, src_rd_en=0 and no increment. Rows issue in ascending order 0..num_rows-1, one per cycle.
- Alignment: a RD_LAT-stage shift register carries {valid, addr}. dpath_sum_en and dpath_result_wraddr equal src_rd_en and src_rd_addr delayed exactly RD_LAT cycles. Both outputs are registered.
- Retirement: retired increments by 1 in each cycle where row_wr_en[0]=1. This is counted in any state except IDLE/DONE; in those states strobes are ignored.
- Lane consistency: if row_wr_en is neither all-0 nor all-1 in any cycle while busy, set err=1. err stays set until the next accepted start and does not abort the job.
- Overrun: a retirement arriving when retired==num_rows_latched sets err and is not counted.
- start outside IDLE is ignored; num_rows is not re-sampled.
- num_rows>ROW_NUM is clamped to ROW_NUM at sampling.
- hold has no effect in DRAIN, DONE or IDLE.
- Completion does not depend on datapath latency. DRAIN waits indefinitely; there is no timeout.

Optional Feature:
Macro MM_BRAM_CTRL_PERF_EN.
- Defined: adds output perf_cycles [31:0] and output perf_stall [31:0].
  - Both clear on accepted start.
  - perf_cycles counts cycles while busy=1.
  - perf_stall counts ISSUE cycles with hold=1.
  - Both saturate at all-ones and hold their value after done.
- Undefined: the ports and counters are absent, with no other change in behaviour.

Decomposition:
- Package mm_bram_ctrl_pkg holds:
  - the state enum typedef (IDLE, ISSUE, DRAIN, DONE)
  - a localparam for the maximum RD_LAT (4)
- One sub-module, mm_bram_ctrl_delay: a parameterised depth-RD_LAT valid+addr shift register with async reset, used for alignment.

Test Plan:
- Set RD_LAT=1, num_rows=4, hold=0, and a model datapath with 3-cycle latency -> src_rd_addr 0,1,2,3 on consecutive cycles; dpath_sum_en high cycles 2-5 after start with wraddr 0..3; done pulses 1 cycle after the 4th all-ones row_wr_en; err=0.
- Hold=1 for 2 cycles after the 2nd issue, num_rows=4 -> issue gap of 2 cycles; addresses still 0..3 with none repeated; done after 4 retirements; perf_stall=2 with PERF_EN.
- start with num_rows=0 -> busy never rises; done pulses the cycle after start; no src_rd_en.
- row_wr_en=32'h0000_FFFF for one cycle mid-job -> err=1 stays set through done; cleared by the next start.
- Assert reset during DRAIN with 2 rows outstanding -> all outputs 0 immediately; no done; a subsequent start with num_rows=2 completes normally.
- RD_LAT=3, num_rows=ROW_NUM, and start pulsed again while busy -> second start ignored; dpath_sum_en lags src_rd_en by exactly 3 cycles for all 32 rows; exactly one done.

Source files
------------

// File: rtl/mm_bram_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// mm_bram_ctrl_pkg
// Shared types for the parallel BRAM matrix-multiply sequencer.
//   ctrl_state_e : sequencer FSM state encoding (IDLE, ISSUE, DRAIN, DONE)
//   MAX_RD_LAT   : deepest source-SRAM read latency the alignment line supports
// ---------------------------------------------------------------------------
package mm_bram_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } ctrl_state_e;

   localparam int MAX_RD_LAT = 4;

endpackage

// File: rtl/mm_bram_ctrl_delay.sv
// ---------------------------------------------------------------------------
// mm_bram_ctrl_delay
// Depth-DEPTH shift register carrying {valid, addr}; output equals the input
// delayed exactly DEPTH cycles. Asynchronous active-high reset clears every
// stage.
// Ports:
//   clk, reset          : clock, async active-high reset
//   valid_i, addr_i     : stage-0 input
//   valid_o, addr_o     : last-stage output (registered)
// ---------------------------------------------------------------------------
module mm_bram_ctrl_delay #(
   parameter int DEPTH = 1,
   parameter int AW    = 5
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          valid_i,
   input  logic [AW-1:0] addr_i,
   output logic          valid_o,
   output logic [AW-1:0] addr_o
);

   logic [DEPTH-1:0] valid_q;
   logic [AW-1:0]    addr_q [DEPTH];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         valid_q <= '0;
         for (int i = 0; i < DEPTH; i++) addr_q[i] <= '0;
      end else begin
         valid_q[0] <= valid_i;
         addr_q[0]  <= addr_i;
         for (int i = 1; i < DEPTH; i++) begin
            valid_q[i] <= valid_q[i-1];
            addr_q[i]  <= addr_q[i-1];
         end
      end
   end

   assign valid_o = valid_q[DEPTH-1];
   assign addr_o  = addr_q[DEPTH-1];

endmodule

// File: rtl/mm_bram_parallel_ctrl.sv
// ---------------------------------------------------------------------------
// mm_bram_parallel_ctrl
// Sequencer for the parallel BRAM matrix-multiply datapath. On an accepted
// start it issues row reads 0..num_rows-1 to the source SRAM (one per cycle,
// paused by hold), re-times valid/address by RD_LAT cycles toward the
// datapath, counts write-backs (row_wr_en[0]) until every row retired, then
// pulses done. err flags mixed lane strobes or write-backs beyond the job.
//
// Handshake: start is a single-cycle request, honoured only in IDLE; there
// is no back-pressure from the datapath, row_wr_en is a pure strobe.
//
// Ports:
//   clk, reset            : clock, async active-high reset
//   start, num_rows       : job request and row count (clamped to ROW_NUM)
//   hold                  : stalls row issue in ISSUE only
//   busy, done, err       : job status
//   src_rd_en/addr        : source SRAM read port
//   dpath_sum_en/wraddr   : read data valid + result address to datapath
//   row_wr_en             : per-lane write strobes from datapath
//   dbg_state             : current FSM state
//   perf_cycles/perf_stall: only with MM_BRAM_CTRL_PERF_EN defined
//
// Optional feature macro: MM_BRAM_CTRL_PERF_EN (busy/stall cycle counters).
// ---------------------------------------------------------------------------
module mm_bram_parallel_ctrl
   import mm_bram_ctrl_pkg::*;
#(
   parameter int ROW_NUM = 32,
   parameter int COL_NUM = 32,
   parameter int RD_LAT  = 1,
   localparam int ROW_ADDR_WIDTH = $clog2(ROW_NUM),
   localparam int CNT_WIDTH      = $clog2(ROW_NUM + 1)
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      start,
   input  logic [CNT_WIDTH-1:0]      num_rows,
   input  logic                      hold,
   output logic                      busy,
   output logic                      done,
   output logic                      err,
   output logic                      src_rd_en,
   output logic [ROW_ADDR_WIDTH-1:0] src_rd_addr,
   output logic                      dpath_sum_en,
   output logic [ROW_ADDR_WIDTH-1:0] dpath_result_wraddr,
   input  logic [COL_NUM-1:0]        row_wr_en,
   output ctrl_state_e               dbg_state
`ifdef MM_BRAM_CTRL_PERF_EN
   ,
   output logic [31:0]               perf_cycles,
   output logic [31:0]               perf_stall
`endif
);

   localparam logic [CNT_WIDTH-1:0] ROW_NUM_C = CNT_WIDTH'(ROW_NUM);
   localparam logic [CNT_WIDTH-1:0] ONE_C     = CNT_WIDTH'(1);

   if (RD_LAT < 1 || RD_LAT > MAX_RD_LAT) begin : g_bad_rd_lat
      $error("RD_LAT out of supported range");
   end

   ctrl_state_e          state_q, state_d;
   logic [CNT_WIDTH-1:0] num_rows_q, num_rows_d;
   logic [CNT_WIDTH-1:0] issue_cnt_q, issue_cnt_d;
   logic [CNT_WIDTH-1:0] retired_q, retired_d;
   logic                 err_q, err_d;
   logic [CNT_WIDTH-1:0] rows_clamped;
   logic                 start_ok, issue_fire, counting, lanes_mixed;

   always_comb begin
      rows_clamped = (num_rows > ROW_NUM_C) ? ROW_NUM_C : num_rows;
      start_ok     = (state_q == IDLE) && start;
      issue_fire   = (state_q == ISSUE) && !hold;
      counting     = (state_q == ISSUE) || (state_q == DRAIN);
      // lanes must move together; any partial strobe is a datapath fault
      lanes_mixed  = (row_wr_en != '0) && (row_wr_en != '1);
   end

   always_comb begin
      state_d     = state_q;
      num_rows_d  = num_rows_q;
      issue_cnt_d = issue_cnt_q;
      retired_d   = retired_q;
      err_d       = err_q;

      case (state_q)
         IDLE: begin
            if (start) begin
               num_rows_d  = rows_clamped;
               issue_cnt_d = '0;
               retired_d   = '0;
               err_d       = 1'b0;
               state_d     = (rows_clamped == '0) ? DONE : ISSUE;
            end
         end
         ISSUE: begin
            if (issue_fire) begin
               issue_cnt_d = issue_cnt_q + ONE_C;
               if (issue_cnt_q == num_rows_q - ONE_C) state_d = DRAIN;
            end
         end
         DONE:    state_d = IDLE;
         default: ;
      endcase

      if (counting) begin
         if (lanes_mixed) err_d = 1'b1;
         if (row_wr_en[0]) begin
            // a write-back beyond the job is flagged, never counted
            if (retired_q == num_rows_q) err_d = 1'b1;
            else                         retired_d = retired_q + ONE_C;
         end
      end

      // finish in the cycle right after the last write-back
      if (state_q == DRAIN && retired_d == num_rows_q) state_d = DONE;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         num_rows_q  <= '0;
         issue_cnt_q <= '0;
         retired_q   <= '0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         num_rows_q  <= num_rows_d;
         issue_cnt_q <= issue_cnt_d;
         retired_q   <= retired_d;
         err_q       <= err_d;
      end
   end

   assign busy        = counting;
   assign done        = (state_q == DONE);
   assign err         = err_q;
   assign src_rd_en   = issue_fire;
   assign src_rd_addr = issue_fire ? issue_cnt_q[ROW_ADDR_WIDTH-1:0] : '0;
   assign dbg_state   = state_q;

   mm_bram_ctrl_delay #(
      .DEPTH (RD_LAT),
      .AW    (ROW_ADDR_WIDTH)
   ) u_delay (
      .clk     (clk),
      .reset   (reset),
      .valid_i (src_rd_en),
      .addr_i  (src_rd_addr),
      .valid_o (dpath_sum_en),
      .addr_o  (dpath_result_wraddr)
   );

`ifdef MM_BRAM_CTRL_PERF_EN
   logic [31:0] perf_cycles_q, perf_stall_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         perf_cycles_q <= '0;
         perf_stall_q  <= '0;
      end else if (start_ok) begin
         perf_cycles_q <= '0;
         perf_stall_q  <= '0;
      end else begin
         if (counting && perf_cycles_q != '1)
            perf_cycles_q <= perf_cycles_q + 32'd1;
         if (state_q == ISSUE && hold && perf_stall_q != '1)
            perf_stall_q <= perf_stall_q + 32'd1;
      end
   end

   assign perf_cycles = perf_cycles_q;
   assign perf_stall  = perf_stall_q;
`endif

endmodule
